// File: rtl/scan_timing_gen.sv
// Digit-scan timing generator for multiplexed 7-segment / LED-matrix displays.
// Define SCAN_BLANK_EN to insert BLANK_CYCLES of dead time between digits.
module scan_timing_gen #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 32768,
    parameter int BLANK_CYCLES = 16,
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [IDX_W-1:0]      digit_idx,
    output logic [NUM_DIGITS-1:0] digit_onehot,
    output logic                  digit_valid,
    output logic                  frame_start
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
    localparam bit USE_BLANK = (BLANK_CYCLES > 0);
    localparam int BW = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BLANK_CYCLES - 1);
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          wrap_q, wrap_d;
`else
    typedef enum logic {IDLE, SHOW} state_t;
    localparam bit USE_BLANK = 1'b0 & (BLANK_CYCLES > 0);
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] onehot_q, onehot_d;
    logic                  valid_q, valid_d;
    logic                  fs_q, fs_d;
    logic [IDX_W-1:0]      low, nxt;
    logic                  wrap;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        fs_d     = 1'b0;
`ifdef SCAN_BLANK_EN
        bcnt_d   = bcnt_q;
        wrap_d   = wrap_q;
`endif
        low = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            if (digit_mask[i]) low = IDX_W'(i);
        // Lowest set bit above the current index, else wrap to lowest overall
        nxt = low;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            if (digit_mask[i] && (IDX_W'(i) > idx_q)) nxt = IDX_W'(i);
        wrap = (nxt <= idx_q);

        if (!en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            onehot_d = '0;
            valid_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|digit_mask) begin
                        state_d  = SHOW;
                        cnt_d    = '0;
                        idx_d    = low;
                        onehot_d = NUM_DIGITS'(1) << low;
                        valid_d  = 1'b1;
                        fs_d     = 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (digit_mask == '0) begin
                            state_d  = IDLE;
                            idx_d    = '0;
                            onehot_d = '0;
                            valid_d  = 1'b0;
                        end else if (USE_BLANK) begin
`ifdef SCAN_BLANK_EN
                            state_d  = BLANK;
                            bcnt_d   = '0;
                            wrap_d   = wrap;
                            idx_d    = nxt;
                            onehot_d = '0;
                            valid_d  = 1'b0;
`endif
                        end else begin
                            idx_d    = nxt;
                            onehot_d = NUM_DIGITS'(1) << nxt;
                            fs_d     = wrap;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef SCAN_BLANK_EN
                BLANK: begin
                    if (bcnt_q == BLAST) begin
                        state_d  = SHOW;
                        cnt_d    = '0;
                        onehot_d = NUM_DIGITS'(1) << idx_q;
                        valid_d  = 1'b1;
                        fs_d     = wrap_q;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
`ifdef SCAN_BLANK_EN
            bcnt_q   <= '0;
            wrap_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
`ifdef SCAN_BLANK_EN
            bcnt_q   <= bcnt_d;
            wrap_q   <= wrap_d;
`endif
        end
    end

    assign digit_idx    = idx_q;
    assign digit_onehot = onehot_q;
    assign digit_valid  = valid_q;
    assign frame_start  = fs_q;

endmodule

// File: tb/tb_scan_timing_gen.sv
// Directed-vector bench for scan_timing_gen (4 digits, 4-cycle slots).
module tb_scan_timing_gen;
    localparam int ND = 4;
    localparam int TD = 4;
    localparam int BC = 2;
`ifdef SCAN_BLANK_EN
    localparam int PER = TD + BC;
`else
    localparam int PER = TD;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [3:0] digit_mask = 4'h0;
    logic [1:0] digit_idx;
    logic [3:0] digit_onehot;
    logic       digit_valid;
    logic       frame_start;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    scan_timing_gen #(
        .NUM_DIGITS  (ND),
        .TICK_DIV    (TD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .digit_mask  (digit_mask),
        .digit_idx   (digit_idx),
        .digit_onehot(digit_onehot),
        .digit_valid (digit_valid),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pop(input logic [3:0] m);
        int c = 0;
        for (int i = 0; i < 4; i++) if (m[i]) c++;
        return c;
    endfunction

    function automatic int nth(input logic [3:0] m, input int n);
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (c == n) return i;
                c++;
            end
        end
        return 0;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, " idx"}, 32'(digit_idx), 0);
        chk({tag, " onehot"}, 32'(digit_onehot), 0);
        chk({tag, " valid"}, 32'(digit_valid), 0);
        chk({tag, " fs"}, 32'(frame_start), 0);
    endtask

    // Expected sequence for a static mask, starting at frame cycle k0
    task automatic run(input string tag, input logic [3:0] m,
                       input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) begin
            int s, ph, c, ei;
            bit on;
            s  = k / PER;
            ph = k % PER;
            c  = pop(m);
            on = (ph < TD);
            ei = on ? nth(m, s % c) : nth(m, (s + 1) % c);
            chk($sformatf("%s k%0d idx", tag, k), 32'(digit_idx), ei);
            chk($sformatf("%s k%0d onehot", tag, k), 32'(digit_onehot),
                on ? (1 << ei) : 0);
            chk($sformatf("%s k%0d valid", tag, k), 32'(digit_valid), 32'(on));
            chk($sformatf("%s k%0d fs", tag, k), 32'(frame_start),
                32'((ph == 0) && (s % c == 0)));
            tick();
        end
    endtask

    task automatic restart(input logic [3:0] m);
        en = 1'b0;
        tick();
        chk_idle("restart");
        digit_mask = m;
        en = 1'b1;
        tick();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #11;
        chk_idle("reset");
        rst_n = 1'b1;
        tick();
        chk_idle("idle en0");

        // all four digits
        digit_mask = 4'hF;
        en = 1'b1;
        tick();
        run("t1", 4'hF, 0, 8 * PER);

        // alternate digits
        restart(4'b0101);
        run("t2", 4'b0101, 0, 4 * PER);

        // empty mask stays idle, then single digit
        en = 1'b0;
        tick();
        digit_mask = 4'h0;
        en = 1'b1;
        tick();
        chk_idle("t3 m0 a");
        tick();
        chk_idle("t3 m0 b");
        digit_mask = 4'b1000;
        tick();
        run("t3", 4'b1000, 0, 3 * PER);

        // en drop mid-slot of digit 1
        restart(4'hF);
        run("t4a", 4'hF, 0, PER + 2);
        en = 1'b0;
        tick();
        chk_idle("t4 drop");
        en = 1'b1;
        tick();
        run("t4b", 4'hF, 0, PER);

        // async reset mid-slot
        restart(4'hF);
        run("t5a", 4'hF, 0, PER + 1);
        rst_n = 1'b0;
        #1;
        chk_idle("t5 async");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run("t5b", 4'hF, 0, 4 * PER);

        // mask cleared mid-slot: holds until boundary, then idle
        restart(4'hF);
        tick();
        digit_mask = 4'h0;
        tick();
        chk("t6 hold idx", 32'(digit_idx), 0);
        chk("t6 hold onehot", 32'(digit_onehot), 1);
        tick();
        tick();
        chk_idle("t6 bound");

        // mask change mid-slot takes effect at boundary
        restart(4'hF);
        tick();
        digit_mask = 4'b1000;
        repeat (PER - 1) tick();
        chk("t7 idx", 32'(digit_idx), 3);
        chk("t7 onehot", 32'(digit_onehot), 4'b1000);
        chk("t7 fs", 32'(frame_start), 0);
        repeat (PER) tick();
        chk("t7 wrap idx", 32'(digit_idx), 3);
        chk("t7 wrap fs", 32'(frame_start), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
